uart_rx_fifo: RTL

//  Asynchronous serial receiver (8N1, LSB first) with a receive FIFO: the receive-side

---
 rtl/uart_rx_fifo.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver (LSB first) with start/stop validation feeding a
// first-word-fall-through receive FIFO that is popped one byte at a time.
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 10000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          RX,
  input  logic          rd_en,
  input  logic          clear_errors,
  output logic [7:0]    data_out,
  output logic          rx_valid,
  output logic [AW:0]   fifo_count,
  output logic          overrun,
  output logic          framing_error
);

  // state      | meaning
  // WAIT_IDLE  | line must return high before any frame may start
  // IDLE       | line idle, waiting for a falling edge
  // START      | timing to mid start bit to reject glitches
  // DATA       | sampling 8 data bits, one per bit period
  // STOP       | sampling the stop bit, then push or flag
  localparam int DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF_TC = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(DIV - 1);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            rx_m, rx_s;
  logic            tc, push, frame_bad;

  logic [AW:0]     wr_ptr, rd_ptr;
  logic [7:0]      mem [FIFO_DEPTH];
  logic            empty, full, pop, wr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  always_comb begin
    tc        = (cnt == ((state == START) ? HALF_TC : FULL_TC));
    push      = (state == STOP) && tc && rx_s;
    frame_bad = (state == STOP) && tc && !rx_s;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= WAIT_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        WAIT_IDLE: if (rx_s) state <= IDLE;
        IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (tc) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (tc) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (tc) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : WAIT_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop   = rd_en && !empty;
    wr    = push && (!full || pop);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      overrun       <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && full && !pop) overrun <= 1'b1;
      else if (clear_errors)    overrun <= 1'b0;
      if (frame_bad)            framing_error <= 1'b1;
      else if (clear_errors)    framing_error <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  assign data_out   = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign rx_valid   = !empty;
  assign fifo_count = wr_ptr - rd_ptr;

endmodule
